mux_2to1: RTL and testbench
===========================

MUX_2TO1 -- requirements
Module: mux_2to1

Interface
REQ-001 Parameter WIDTH, default 1: data width of a_in, b_in and y_out, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of sw_cnt_out, legal range 4..32.
REQ-003 Port clk_in, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_in, input, 1: reset, asynchronous and active-high.
REQ-005 Port a_in, input, WIDTH: data input selected when set_in=0.
REQ-006 Port b_in, input, WIDTH: data input selected when set_in=1.
REQ-007 Port set_in, input, 1: select line.
REQ-008 Port en_in, input, 1: capture enable; 1 = load a new output value, 0 = hold.
REQ-009 Port y_out, output, WIDTH: registered mux result.
REQ-010 Port y_valid_out, output, 1: high when y_out holds a value captured since the last reset.
REQ-011 Port sw_cnt_out, output, CNT_W: select-switch counter; present only with MUX_2TO1_SWCNT_EN.

Function
REQ-012 At each rising clk_in edge with en_in=1, y_out SHALL load a_in if set_in=0, else b_in.
REQ-013 Latency SHALL be exactly one cycle, with no combinational path from any input to y_out.
REQ-014 At each rising edge with en_in=0, y_out and y_valid_out SHALL hold their values.
REQ-015 y_valid_out SHALL go to 1 at the first rising edge with en_in=1 after reset and stay 1 until the next reset.
REQ-016 The mux SHALL treat a set_in value of X or Z as undefined; there is no defined output requirement for this case.
REQ-017 Each WIDTH bit SHALL be selected by the same set_in, with no per-bit select.
REQ-018 The block SHALL record the select value of the last load in an internal register, sel_q.
REQ-019 A switch event occurs when a load (en_in=1) has set_in different from sel_q.
REQ-020 Switch events SHALL only be counted after y_valid_out=1, so the first load after reset is never counted.

Reset
REQ-021 While rst_in=1, independent of clk_in: y_out=0, y_valid_out=0, sel_q=0, sw_cnt_out=0.
REQ-022 On release of rst_in, the first capture SHALL occur at the first rising edge with en_in=1.
REQ-023 Asserting rst_in in mid-operation SHALL clear all state immediately, with no partial update.

Configuration
REQ-024 With macro MUX_2TO1_SWCNT_EN defined, sw_cnt_out SHALL exist and count switch events.
REQ-025 The counter SHALL increment by 1 per switch event and saturate at 2^CNT_W-1 without wrapping.
REQ-026 Without MUX_2TO1_SWCNT_EN, the sw_cnt_out port and counter logic SHALL be absent.
REQ-027 All other behaviour SHALL be identical with or without the macro.

Structure
REQ-028 Package mux_2to1_pkg SHALL hold the WIDTH default, the CNT_W default and the saturation constant, as a function of CNT_W.
REQ-029 The optional counter SHALL be a sub-module, mux_2to1_swcnt: inputs clock, reset, event, and output count.
REQ-030 The top level SHALL instantiate mux_2to1_swcnt only under MUX_2TO1_SWCNT_EN.

Verification
REQ-031 Reset pulse mid-run -> y_out=0, y_valid_out=0 and sw_cnt_out=0 immediately, without waiting for a clock edge.
REQ-032 WIDTH=1, en_in=1, sweep all 8 {a_in,b_in,set_in} combos one per cycle -> y_out one cycle later equals set_in ? b_in : a_in (e.g. a=1,b=0,set=1 -> 0).
REQ-033 WIDTH=8, a_in=8'hA5, b_in=8'h3C, set_in=1, en_in=1 -> y_out=8'h3C next cycle, then en_in=0 and inputs changed -> y_out stays 8'h3C.
REQ-034 First load after reset with set_in=1 -> y_valid_out=1 and sw_cnt_out=0; the next load with set_in=0 -> sw_cnt_out=1.
REQ-035 CNT_W=4, toggle set_in on 20 consecutive enabled loads -> sw_cnt_out saturates at 15.
REQ-036 Build without MUX_2TO1_SWCNT_EN -> no sw_cnt_out port, and scenarios REQ-032 and REQ-033 give the same results.

Source files
------------

// File: rtl/mux_2to1_pkg.sv
// Shared defaults and helpers for the registered 2:1 mux.
// Holds the data/counter width defaults and the counter ceiling.
package mux_2to1_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 16;

  // Largest value a cnt_w-bit counter holds; 33-bit math covers cnt_w=32
  function automatic logic [31:0] sat_max(input int cnt_w);
    logic [32:0] w_full;
    w_full  = (33'd1 << cnt_w) - 33'd1;
    sat_max = w_full[31:0];
  endfunction

  localparam logic [31:0] SAT_DEF = sat_max(CNT_W_DEF);

endpackage

// File: rtl/mux_2to1_swcnt.sv
// Saturating event counter used to tally select-line switches.
// Holds at its ceiling instead of wrapping.
module mux_2to1_swcnt
  import mux_2to1_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             evt_in,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] r_cnt;
  logic             w_room;

  assign w_room = (r_cnt != SAT);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt <= '0;
    end else if (evt_in && w_room) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_out = r_cnt;

endmodule

// File: rtl/mux_2to1.sv
// Registered 2:1 mux with capture enable and valid flag.
// Optional select-switch counter: define MUX_2TO1_SWCNT_EN.
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             set_in,
  input  logic             en_in,
  output logic [WIDTH-1:0] y_out,
`ifdef MUX_2TO1_SWCNT_EN
  output logic             y_valid_out,
  output logic [CNT_W-1:0] sw_cnt_out
`else
  output logic             y_valid_out
`endif
);

  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;

  assign w_mux = set_in ? b_in : a_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else if (en_in) begin
      r_y     <= w_mux;
      r_valid <= 1'b1;
    end
  end

  assign y_out       = r_y;
  assign y_valid_out = r_valid;

`ifdef MUX_2TO1_SWCNT_EN
  logic r_sel_q;
  logic w_switch;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sel_q <= 1'b0;
    end else if (en_in) begin
      r_sel_q <= set_in;
    end
  end

  // Gating on r_valid keeps the first load after reset uncounted
  assign w_switch = en_in & r_valid & (set_in != r_sel_q);

  mux_2to1_swcnt #(
    .CNT_W (CNT_W)
  ) u_swcnt (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .evt_in  (w_switch),
    .cnt_out (sw_cnt_out)
  );
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed + random bench for mux_2to1 (1-bit and 8-bit instances).
// Expected values come from a load-history model kept in the bench.
module tb_mux_2to1;

  logic       clk;
  logic       rst;
  logic       en;
  logic       set;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic       y1, v1;
  logic [7:0] y8;
  logic       v8;
`ifdef MUX_2TO1_SWCNT_EN
  logic [3:0]  c1;
  logic [15:0] c8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // model: outputs of the last load plus every select loaded since reset
  logic       m_y1;
  logic [7:0] m_y8;
  logic       m_v;
  bit         sel_hist[$];

  mux_2to1 #(.WIDTH(1), .CNT_W(4)) u_w1 (
    .clk_in      (clk),
    .rst_in      (rst),
    .a_in        (a1),
    .b_in        (b1),
    .set_in      (set),
    .en_in       (en),
    .y_out       (y1),
`ifdef MUX_2TO1_SWCNT_EN
    .y_valid_out (v1),
    .sw_cnt_out  (c1)
`else
    .y_valid_out (v1)
`endif
  );

  mux_2to1 #(.WIDTH(8), .CNT_W(16)) u_w8 (
    .clk_in      (clk),
    .rst_in      (rst),
    .a_in        (a8),
    .b_in        (b8),
    .set_in      (set),
    .en_in       (en),
    .y_out       (y8),
`ifdef MUX_2TO1_SWCNT_EN
    .y_valid_out (v8),
    .sw_cnt_out  (c8)
`else
    .y_valid_out (v8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int switches();
    int s = 0;
    for (int i = 1; i < sel_hist.size(); i++)
      if (sel_hist[i] != sel_hist[i-1]) s++;
    return s;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_y1 = 1'b0;
    m_y8 = 8'h00;
    m_v  = 1'b0;
    sel_hist.delete();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y1"}, 64'(y1), 64'(m_y1));
    check({tag, ".y8"}, 64'(y8), 64'(m_y8));
    check({tag, ".v1"}, 64'(v1), 64'(m_v));
    check({tag, ".v8"}, 64'(v8), 64'(m_v));
`ifdef MUX_2TO1_SWCNT_EN
    check({tag, ".c1"}, 64'(c1), 64'(sat(switches(), 15)));
    check({tag, ".c8"}, 64'(c8), 64'(sat(switches(), 65535)));
`endif
  endtask

  // drive inputs, take one rising edge, update model, sample 1ns later
  task automatic step(input string tag, input logic e, input logic s,
                      input logic ia1, input logic ib1,
                      input logic [7:0] ia8, input logic [7:0] ib8);
    en = e; set = s; a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8;
    @(posedge clk);
    if (e) begin
      m_y1 = s ? ib1 : ia1;
      m_y8 = s ? ib8 : ia8;
      m_v  = 1'b1;
      sel_hist.push_back(s);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] combo;
    bit         s;
    rst = 1'b1; en = 1'b0; set = 1'b0;
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    model_reset();
    #1;
    check_all("reset");
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst_idle");

    step("hold_before_load", 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);

    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      step("sweep_w1", 1'b1, combo[0], combo[2], combo[1],
           8'($urandom), 8'($urandom));
    end

    step("a5_3c_load", 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C);
    check("a5_3c_y", 64'(y8), 64'h3C);
    step("a5_3c_hold0", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
    step("a5_3c_hold1", 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'hC3);
    check("a5_3c_held", 64'(y8), 64'h3C);

    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst = 1'b0;
    step("rst_release_idle", 1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 8'h88);

    step("first_load_s1", 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
`ifdef MUX_2TO1_SWCNT_EN
    check("first_load_cnt", 64'(c8), 64'd0);
`endif
    step("second_load_s0", 1'b1, 1'b0, 1'b1, 1'b0, 8'h56, 8'h78);
`ifdef MUX_2TO1_SWCNT_EN
    check("second_load_cnt", 64'(c8), 64'd1);
`endif

    s = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s = ~s;
      step("toggle", 1'b1, s, 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom));
    end
`ifdef MUX_2TO1_SWCNT_EN
    check("sat_c1", 64'(c1), 64'd15);
    check("sat_c8", 64'(c8), 64'd21);
`endif

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rand_rst");
        #2;
        rst = 1'b0;
      end
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
